// File: rtl/ctl_pkg.sv
// Shared definitions for the stopwatch run-control FSM.
package ctl_pkg;

  localparam int unsigned STATE_W = 2;

  // Run-control states; encoding 2'b11 is unused and decodes to IDLE.
  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'b00,
    COUNTING = 2'b01,
    PAUSED   = 2'b10
  } state_t;

endpackage

// File: rtl/ctl.sv
// Stopwatch run-control FSM: trig starts/stops, split clears while paused.
module ctl
  import ctl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic trig,
  input  logic split,
  output logic init_regs,
  output logic count_enabled
);

  state_t state;
  state_t state_next;
  logic   init_regs_next;
  logic   count_enabled_next;

  // State and output registers; reset forces IDLE outputs immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      init_regs     <= 1'b1;
      count_enabled <= 1'b0;
    end else begin
      state         <= state_next;
      init_regs     <= init_regs_next;
      count_enabled <= count_enabled_next;
    end
  end

  // Next-state logic; outputs are decoded from the next state so the
  // registered outputs always match the registered state.
  always_comb begin
    state_next         = IDLE;
    init_regs_next     = 1'b0;
    count_enabled_next = 1'b0;

    case (state)
      IDLE: begin
        if (trig) state_next = COUNTING;
        else      state_next = IDLE;
      end
      COUNTING: begin
        // split is ignored here; the display freeze lives downstream.
        if (trig) state_next = PAUSED;
        else      state_next = COUNTING;
      end
      PAUSED: begin
        // split has priority over trig when both arrive together.
        if (split)     state_next = IDLE;
        else if (trig) state_next = COUNTING;
        else           state_next = PAUSED;
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      COUNTING: count_enabled_next = 1'b1;
      PAUSED:   ;
      default:  init_regs_next     = 1'b1;
    endcase
  end

  // The datapath must never be cleared and advanced in the same cycle.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(init_regs && count_enabled))
        else $error("ctl: init_regs and count_enabled both high");
    end
  end

endmodule

// File: tb/tb_ctl.sv
// Self-checking bench for the stopwatch run-control FSM.
module tb_ctl;

  logic clk = 1'b0;
  logic reset;
  logic trig;
  logic split;
  logic init_regs;
  logic count_enabled;

  int checks   = 0;
  int failures = 0;

  // Reference model: "cleared" and "running" flags of the stopwatch.
  bit m_clr;
  bit m_run;

  ctl dut (
    .clk           (clk),
    .reset         (reset),
    .trig          (trig),
    .split         (split),
    .init_regs     (init_regs),
    .count_enabled (count_enabled)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_clr = 1'b1;
    m_run = 1'b0;
  endtask

  // A split clears only a stopped, non-cleared watch; otherwise trig
  // starts a cleared watch or flips running/stopped.
  task automatic model_edge(input logic t, input logic s);
    if (!m_clr && !m_run && s) begin
      m_clr = 1'b1;
    end else if (t) begin
      if (m_clr) begin
        m_clr = 1'b0;
        m_run = 1'b1;
      end else begin
        m_run = !m_run;
      end
    end
  endtask

  // Drive one cycle of inputs at negedge, advance past the posedge.
  task automatic cycle(input logic t, input logic s);
    @(negedge clk);
    trig  = t;
    split = s;
    @(posedge clk);
    model_edge(t, s);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    trig  = 1'b0;
    split = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    trig  = 1'b0;
    split = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({init_regs, count_enabled} !== 2'b10) begin
      failures++;
      $display("FAIL reset_held: got %b want 10", {init_regs, count_enabled});
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cycle(1'b0, 1'b0);
    checks++;
    if ({init_regs, count_enabled} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release: got %b want 10", {init_regs, count_enabled});
    end
    cycle(1'b0, 1'b1);
    checks++;
    if ({init_regs, count_enabled} !== 2'b10) begin
      failures++;
      $display("FAIL idle_split_ignored: got %b want 10", {init_regs, count_enabled});
    end
  endtask

  task automatic test_start_stop();
    cycle(1'b1, 1'b0);
    checks++;
    if ({init_regs, count_enabled} !== 2'b01) begin
      failures++;
      $display("FAIL start: got %b want 01", {init_regs, count_enabled});
    end
    cycle(1'b0, 1'b0);
    checks++;
    if ({init_regs, count_enabled} !== 2'b01) begin
      failures++;
      $display("FAIL counting_hold: got %b want 01", {init_regs, count_enabled});
    end
    cycle(1'b0, 1'b1);
    checks++;
    if ({init_regs, count_enabled} !== 2'b01) begin
      failures++;
      $display("FAIL counting_split_ignored: got %b want 01", {init_regs, count_enabled});
    end
    cycle(1'b1, 1'b0);
    checks++;
    if ({init_regs, count_enabled} !== 2'b00) begin
      failures++;
      $display("FAIL stop: got %b want 00", {init_regs, count_enabled});
    end
  endtask

  task automatic test_held_trig();
    cycle(1'b1, 1'b0);
    checks++;
    if ({init_regs, count_enabled} !== 2'b01) begin
      failures++;
      $display("FAIL held_trig_first: got %b want 01", {init_regs, count_enabled});
    end
    cycle(1'b1, 1'b0);
    checks++;
    if ({init_regs, count_enabled} !== 2'b00) begin
      failures++;
      $display("FAIL held_trig_second: got %b want 00", {init_regs, count_enabled});
    end
    cycle(1'b0, 1'b0);
    checks++;
    if ({init_regs, count_enabled} !== 2'b00) begin
      failures++;
      $display("FAIL paused_hold: got %b want 00", {init_regs, count_enabled});
    end
  endtask

  task automatic test_split();
    cycle(1'b0, 1'b1);
    checks++;
    if ({init_regs, count_enabled} !== 2'b10) begin
      failures++;
      $display("FAIL paused_split: got %b want 10", {init_regs, count_enabled});
    end
    // Back to PAUSED, then trig and split together: split wins.
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    checks++;
    if ({init_regs, count_enabled} !== 2'b00) begin
      failures++;
      $display("FAIL repause: got %b want 00", {init_regs, count_enabled});
    end
    cycle(1'b1, 1'b1);
    checks++;
    if ({init_regs, count_enabled} !== 2'b10) begin
      failures++;
      $display("FAIL split_beats_trig: got %b want 10", {init_regs, count_enabled});
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    checks++;
    if ({init_regs, count_enabled} !== 2'b01) begin
      failures++;
      $display("FAIL pre_async_counting: got %b want 01", {init_regs, count_enabled});
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({init_regs, count_enabled} !== 2'b10) begin
      failures++;
      $display("FAIL async_reset: got %b want 10", {init_regs, count_enabled});
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic t;
    logic s;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      t = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 3) == 0);
      cycle(t, s);
      checks++;
      if ({init_regs, count_enabled} !== {m_clr, m_run}) begin
        failures++;
        $display("FAIL random_%0d: got %b want %b", i, {init_regs, count_enabled}, {m_clr, m_run});
      end
      if ($urandom_range(0, 60) == 0) begin
        do_reset();
        checks++;
        if ({init_regs, count_enabled} !== 2'b10) begin
          failures++;
          $display("FAIL random_reset_%0d: got %b want 10", i, {init_regs, count_enabled});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_held_trig();
    test_split();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
